// File: rtl/proc_test_sequencer.sv
// proc_test_sequencer: hardware run controller for the single-cycle MIPS processor.
// On an accepted start it holds the processor in reset for RESET_CYCLES cycles,
// clock-enables it for run_cycles cycles, then scans registers 1..NREGS-1 through
// a debug read port and compares each against an expected-value store.
//
// Ports:
//   clk, reset          system clock; synchronous active-low reset
//   start, run_cycles   run request (IDLE/DONE only) and run length, latched on accept
//   proc_reset, proc_en reset and clock enable driven to the processor
//   reg_addr, reg_data  register-file debug read port (combinational data)
//   exp_data, exp_valid expected value and compare enable for reg_addr
//   busy, done, pass    run status; pass valid while done
//   mismatch_count      number of mismatching checked registers
//   fail_addr/actual/expected  first-mismatch diagnostics
module proc_test_sequencer #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned NREGS         = 32,
  parameter int unsigned CYC_W         = 16,
  parameter int unsigned RESET_CYCLES  = 2,
  parameter int unsigned STOP_ON_FIRST = 0,
  localparam int unsigned AW           = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CYC_W-1:0] run_cycles,
  output logic             proc_reset,
  output logic             proc_en,
  output logic [AW-1:0]    reg_addr,
  input  logic [WIDTH-1:0] reg_data,
  input  logic [WIDTH-1:0] exp_data,
  input  logic             exp_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AW-1:0]    mismatch_count,
  output logic [AW-1:0]    fail_addr,
  output logic [WIDTH-1:0] fail_actual,
  output logic [WIDTH-1:0] fail_expected
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRst   = 3'd1;
  localparam logic [2:0] StRun   = 3'd2;
  localparam logic [2:0] StCheck = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [AW-1:0]    LastAddr = AW'(NREGS - 1);
  localparam logic [CYC_W-1:0] RstLoad  = CYC_W'(RESET_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [CYC_W-1:0] run_q, run_d;
  logic             proc_reset_q, proc_reset_d;
  logic             proc_en_q, proc_en_d;
  logic [AW-1:0]    reg_addr_q, reg_addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [AW-1:0]    mcount_q, mcount_d;
  logic [AW-1:0]    fail_addr_q, fail_addr_d;
  logic [WIDTH-1:0] fail_act_q, fail_act_d;
  logic [WIDTH-1:0] fail_exp_q, fail_exp_d;

  logic             mism;
  logic [AW-1:0]    mcount_next;

  assign mism        = exp_valid && (reg_data != exp_data);
  assign mcount_next = mcount_q + AW'(mism);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_d        = run_q;
    proc_reset_d = proc_reset_q;
    proc_en_d    = proc_en_q;
    reg_addr_d   = reg_addr_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    mcount_d     = mcount_q;
    fail_addr_d  = fail_addr_q;
    fail_act_d   = fail_act_q;
    fail_exp_d   = fail_exp_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StRst;
          run_d        = run_cycles;
          cnt_d        = RstLoad;
          proc_reset_d = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          mcount_d     = '0;
          fail_addr_d  = '0;
          fail_act_d   = '0;
          fail_exp_d   = '0;
        end
      end
      StRst: begin
        if (cnt_q == '0) begin
          proc_reset_d = 1'b0;
          if (run_q == '0) begin
            state_d    = StCheck;
            reg_addr_d = AW'(1);
          end else begin
            state_d   = StRun;
            proc_en_d = 1'b1;
            cnt_d     = run_q - CYC_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CYC_W'(1);
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          state_d    = StCheck;
          proc_en_d  = 1'b0;
          reg_addr_d = AW'(1);
        end else begin
          cnt_d = cnt_q - CYC_W'(1);
        end
      end
      StCheck: begin
        if (mism) begin
          mcount_d = mcount_next;
          // A zero running count means this is the first mismatch of the run.
          if (mcount_q == '0) begin
            fail_addr_d = reg_addr_q;
            fail_act_d  = reg_data;
            fail_exp_d  = exp_data;
          end
        end
        if ((mism && (STOP_ON_FIRST != 0)) || (reg_addr_q == LastAddr)) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (mcount_next == '0);
        end else begin
          reg_addr_d = reg_addr_q + AW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      run_q        <= '0;
      proc_reset_q <= 1'b1;
      proc_en_q    <= 1'b0;
      reg_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      mcount_q     <= '0;
      fail_addr_q  <= '0;
      fail_act_q   <= '0;
      fail_exp_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_q        <= run_d;
      proc_reset_q <= proc_reset_d;
      proc_en_q    <= proc_en_d;
      reg_addr_q   <= reg_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      mcount_q     <= mcount_d;
      fail_addr_q  <= fail_addr_d;
      fail_act_q   <= fail_act_d;
      fail_exp_q   <= fail_exp_d;
    end
  end

  assign proc_reset     = proc_reset_q;
  assign proc_en        = proc_en_q;
  assign reg_addr       = reg_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign mismatch_count = mcount_q;
  assign fail_addr      = fail_addr_q;
  assign fail_actual    = fail_act_q;
  assign fail_expected  = fail_exp_q;

endmodule

// File: tb/tb_proc_test_sequencer.sv
// Bench for proc_test_sequencer: two instances (full scan and stop-on-first) share
// the stimulus and a table-driven register file / expected-value store.
module tb_proc_test_sequencer;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] run_cycles = '0;

  logic [31:0] act_mem [32];
  logic [31:0] exp_mem [32];
  logic        val_mem [32];

  logic          proc_reset0, proc_en0, busy0, done0, pass0;
  logic [AW-1:0] reg_addr0, mcount0, fail_addr0;
  logic [31:0]   fail_act0, fail_exp0, reg_data0, exp_data0;
  logic          exp_valid0;

  logic          proc_reset1, proc_en1, busy1, done1, pass1;
  logic [AW-1:0] reg_addr1, mcount1, fail_addr1;
  logic [31:0]   fail_act1, fail_exp1, reg_data1, exp_data1;
  logic          exp_valid1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign reg_data0  = act_mem[reg_addr0];
  assign exp_data0  = exp_mem[reg_addr0];
  assign exp_valid0 = val_mem[reg_addr0];
  assign reg_data1  = act_mem[reg_addr1];
  assign exp_data1  = exp_mem[reg_addr1];
  assign exp_valid1 = val_mem[reg_addr1];

  proc_test_sequencer #(.STOP_ON_FIRST(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles),
    .proc_reset(proc_reset0), .proc_en(proc_en0), .reg_addr(reg_addr0),
    .reg_data(reg_data0), .exp_data(exp_data0), .exp_valid(exp_valid0),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch_count(mcount0),
    .fail_addr(fail_addr0), .fail_actual(fail_act0), .fail_expected(fail_exp0)
  );

  proc_test_sequencer #(.STOP_ON_FIRST(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles),
    .proc_reset(proc_reset1), .proc_en(proc_en1), .reg_addr(reg_addr1),
    .reg_data(reg_data1), .exp_data(exp_data1), .exp_valid(exp_valid1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_count(mcount1),
    .fail_addr(fail_addr1), .fail_actual(fail_act1), .fail_expected(fail_exp1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Accept a start at the next edge (edge 0), then follow both instances until done.
  // Returns done-rise edge numbers, proc_en high cycles and proc_reset high cycles of u_dut0.
  task automatic run(input int n, input int pulse_at, output int d0, output int d1,
                     output int en, output int rst_hi);
    start      = 1'b1;
    run_cycles = n[15:0];
    @(posedge clk); #1;
    start  = 1'b0;
    d0     = -1;
    d1     = -1;
    en     = 0;
    rst_hi = 0;
    check("busy_after_start", {31'b0, busy0}, 32'd1);
    check("done_after_start", {31'b0, done0}, 32'd0);
    if (proc_reset0) rst_hi++;
    if (proc_en0) en++;
    for (int i = 1; i < 300; i++) begin
      start = (i == pulse_at);
      @(posedge clk); #1;
      if (proc_reset0) rst_hi++;
      if (proc_en0) en++;
      if (d0 < 0 && done0) d0 = i;
      if (d1 < 0 && done1) d1 = i;
      if (d0 >= 0 && d1 >= 0) break;
    end
    start = 1'b0;
    if (d0 < 0 || d1 < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  int d0, d1, en, rst_hi;

  initial begin
    // Fibonacci-style register contents; expected store matches.
    act_mem[0] = '0;
    act_mem[1] = 32'd1;
    for (int i = 2; i < 32; i++) act_mem[i] = act_mem[i-1] + act_mem[i-2];
    for (int i = 0; i < 32; i++) begin
      exp_mem[i] = act_mem[i];
      val_mem[i] = 1'b1;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_proc_reset", {31'b0, proc_reset0}, 32'd1);
    check("rst_proc_en", {31'b0, proc_en0}, 32'd0);
    check("rst_busy", {31'b0, busy0}, 32'd0);
    check("rst_done", {31'b0, done0}, 32'd0);
    check("rst_pass", {31'b0, pass0}, 32'd0);
    check("rst_reg_addr", {27'b0, reg_addr0}, 32'd0);
    check("rst_mcount", {27'b0, mcount0}, 32'd0);
    check("rst_fail_addr", {27'b0, fail_addr0}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // All registers match, N=29: done at edge 62
    run(29, -1, d0, d1, en, rst_hi);
    check("fib_done_edge", d0, 32'd62);
    check("fib_done_edge_sof", d1, 32'd62);
    check("fib_en_cycles", en, 32'd29);
    check("fib_reset_cycles", rst_hi, 32'd2);
    check("fib_pass", {31'b0, pass0}, 32'd1);
    check("fib_mcount", {27'b0, mcount0}, 32'd0);
    check("fib_pass_sof", {31'b0, pass1}, 32'd1);
    check("fib_busy_done", {31'b0, busy0}, 32'd0);

    // Two wrong registers (5 and 9); back-to-back start right as done appears
    exp_mem[5] = 32'hcafebabe;
    act_mem[5] = 32'h00000008;
    exp_mem[9] = 32'h12345678;
    run(29, -1, d0, d1, en, rst_hi);
    check("mm_done_edge", d0, 32'd62);
    check("mm_pass", {31'b0, pass0}, 32'd0);
    check("mm_mcount", {27'b0, mcount0}, 32'd2);
    check("mm_fail_addr", {27'b0, fail_addr0}, 32'd5);
    check("mm_fail_actual", fail_act0, 32'h00000008);
    check("mm_fail_expected", fail_exp0, 32'hcafebabe);
    check("sof_done_edge", d1, 32'd36);
    check("sof_mcount", {27'b0, mcount1}, 32'd1);
    check("sof_fail_addr", {27'b0, fail_addr1}, 32'd5);
    check("sof_pass", {31'b0, pass1}, 32'd0);

    // Mismatching registers masked, zero run length: CHECK at edge 2, done at 33
    val_mem[5] = 1'b0;
    val_mem[9] = 1'b0;
    run(0, -1, d0, d1, en, rst_hi);
    check("mask_pass", {31'b0, pass0}, 32'd1);
    check("mask_pass_sof", {31'b0, pass1}, 32'd1);
    check("zero_run_en", en, 32'd0);
    check("zero_run_done_edge", d0, 32'd33);
    check("mask_fail_cleared", {27'b0, fail_addr0}, 32'd0);

    // start pulsed during RUN is ignored
    run(29, 10, d0, d1, en, rst_hi);
    check("ign_done_edge", d0, 32'd62);
    check("ign_en_cycles", en, 32'd29);

    // Reset mid-run at edge R+3
    start      = 1'b1;
    run_cycles = 16'd29;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_proc_en", {31'b0, proc_en0}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_proc_reset", {31'b0, proc_reset0}, 32'd1);
    check("mid_rst_proc_en", {31'b0, proc_en0}, 32'd0);
    check("mid_rst_busy", {31'b0, busy0}, 32'd0);
    check("mid_rst_done", {31'b0, done0}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_after_rst_busy", {31'b0, busy0}, 32'd0);

    // Fresh start after reset completes normally
    run(29, -1, d0, d1, en, rst_hi);
    check("fresh_done_edge", d0, 32'd62);
    check("fresh_pass", {31'b0, pass0}, 32'd1);
    check("fresh_en_cycles", en, 32'd29);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_test_sequencer.md
# proc_test_sequencer

Synthesizable self-checking run controller for the single-cycle MIPS processor. It replaces the fixed delays and register loop of the simulation bench with hardware. On `start` it holds the processor in reset for a programmable number of cycles, then clock-enables it for a programmable run length. It then scans the processor's register file through a read port, compares each register against an expected-value store, and reports pass/fail with first-failure diagnostics. It sits between the bench (or an on-board host) and `Processor`, and lets the same check run in simulation and on FPGA.

## Interface
Parameters:
- `WIDTH`, 32, register data width
- `NREGS`, 32, register-file depth; register 0 is never checked
- `CYC_W`, 16, width of the run-cycle count
- `RESET_CYCLES`, 2, cycles `proc_reset` is held high per run; must be ≥1
- `STOP_ON_FIRST`, 0, 1 = end the scan at the first mismatch; 0 = scan all registers and count mismatches

Ports (`AW` = $clog2(NREGS)):
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE or DONE
- `run_cycles`  in  CYC_W  processor cycles to execute; latched on an accepted `start`
- `proc_reset`  out  1  active-high reset to `Processor`
- `proc_en`  out  1  clock enable to `Processor`; high only in RUN
- `reg_addr`  out  AW  register-file debug read address
- `reg_data`  in  WIDTH  combinational read data for `reg_addr`
- `exp_data`  in  WIDTH  expected value for `reg_addr`; combinational, same cycle
- `exp_valid`  in  1  1 = compare this register; 0 = don't-care
- `busy`  out  1  high from the accepted `start` until DONE
- `done`  out  1  high in DONE
- `pass`  out  1  valid while `done`; 1 = zero mismatches
- `mismatch_count`  out  AW  number of mismatching checked registers
- `fail_addr`  out  AW  address of the first mismatch
- `fail_actual`, `fail_expected`  out  WIDTH  data captured at the first mismatch

## Operation
- States: IDLE, RST, RUN, CHECK, DONE. All outputs are registered.
- IDLE/DONE with `start`=1: go to RST.
  - Latch `run_cycles`.
  - `proc_reset`<=1, `busy`<=1, `done`<=0, `pass`<=0.
  - Clear `mismatch_count` and all `fail_*` fields.
  - Load the counter with RESET_CYCLES-1.
- RST: decrement the counter. When it reads 0:
  - `proc_reset`<=0.
  - If the latched run count is 0, go to CHECK with `reg_addr`<=1.
  - Otherwise go to RUN with `proc_en`<=1 and the counter loaded with run count-1.
- RUN: decrement the counter. When it reads 0, go to CHECK with `proc_en`<=0 and `reg_addr`<=1. The processor is frozen during CHECK.
- CHECK: one register per cycle. A mismatch is `exp_valid` && `reg_data`!=`exp_data`.
  - On the first mismatch, capture `fail_addr`/`fail_actual`/`fail_expected`.
  - Every mismatch increments `mismatch_count`.
  - STOP_ON_FIRST=1 and a mismatch: go to DONE.
  - Otherwise, at `reg_addr`==NREGS-1, go to DONE; else `reg_addr`++.
- Entering DONE: `busy`<=0, `done`<=1, `pass`<=(final count==0). All results are held until the next accepted `start`.
- `start` in RST/RUN/CHECK is ignored.
- `reset`=0, at any time including mid-run, gives these values on the next edge, regardless of `start`:
  - state IDLE, `proc_reset`=1, `proc_en`=0
  - `busy`=`done`=`pass`=0
  - `reg_addr`=0, `mismatch_count`=0, all `fail_*`=0

## Timing
- Let the accepted `start` be edge 0, R = RESET_CYCLES, N = latched `run_cycles`.
- `proc_reset` is high for edges 1..R (exactly R cycles after edge 0).
- `proc_en` is high for exactly N cycles, starting at edge R.
- CHECK starts at edge R+N and occupies NREGS-1 cycles.
- Full scan: `done` rises at edge R+N+NREGS-1.
- STOP_ON_FIRST with the first mismatch at address k: `done` rises at edge R+N+k.
- Back-to-back: `start` in the same cycle DONE is first visible is accepted. `done` falls on the next edge.

## Test plan
- Defaults, Fibonacci-style model: N=29, all 31 expected values match -> `done` at edge 2+29+31=62, `pass`=1, `mismatch_count`=0, `proc_en` high for exactly 29 cycles.
- STOP_ON_FIRST=0, register 5 expected 0xcafebabe, actual 0x00000008, register 9 also wrong -> `pass`=0, `mismatch_count`=2, `fail_addr`=5, `fail_actual`=0x00000008, `fail_expected`=0xcafebabe.
- Same stimulus with STOP_ON_FIRST=1 -> `done` at edge R+N+5, `mismatch_count`=1, `fail_addr`=5.
- Register 5 mismatch with `exp_valid`=0 at addr 5 -> `pass`=1; `run_cycles`=0 -> `proc_en` never high, CHECK starts at edge R.
- `start` pulsed during RUN -> no restart, same `done` edge. `reset`=0 at edge R+3 -> next edge `proc_reset`=1, `proc_en`=0, `busy`=0, `done`=0. A fresh `start` after reset completes normally.
